mandelbrot_iterator: RTL and testbench

MANDELBROT_ITERATOR -- requirements
Module: mandelbrot_iterator

---
 rtl/mandelbrot_iterator.sv | 128 ++++++++++++
 tb/tb_mandelbrot_iterator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iterator.sv
// Mandelbrot escape-time iterator, 16.16 fixed point; result out_iter+1 edges after accept, held until out_ready.
// One point in flight: in_ready low from accept until result handshake. `MANDEL_ITER_PERF_CNT_EN adds perf_cycles.
module mandelbrot_iterator #(
   parameter int FRAC     = 16,
   parameter int MAX_ITER = 255,
   parameter int ITER_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       c_re,
   input  logic [31:0]       c_im,
   input  logic [9:0]        in_x,
   input  logic [8:0]        in_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ITER_W-1:0] out_iter,
   output logic              out_escaped,
   output logic [9:0]        out_x,
   output logic [8:0]        out_y
`ifdef MANDEL_ITER_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   localparam logic [ITER_W-1:0] MAX_N     = ITER_W'(MAX_ITER);
   localparam logic signed [33:0] ESC_LIM  = 34'sd4 <<< FRAC;

   state_t state, state_nxt;

   logic signed [31:0] z_re, z_im, cr, ci;
   logic [ITER_W-1:0]  n;

   logic signed [63:0] zre64, zim64;
   logic signed [63:0] p_rr, p_ii, p_ri;
   logic signed [31:0] zr2, zi2, zri;
   logic signed [33:0] mag;
   logic               escape;
   logic               at_cap;

   // Full-precision products, then arithmetic shift back to 16.16 and wrap to 32 bits.
   assign zre64  = {{32{z_re[31]}}, z_re};
   assign zim64  = {{32{z_im[31]}}, z_im};
   assign p_rr   = zre64 * zre64;
   assign p_ii   = zim64 * zim64;
   assign p_ri   = zre64 * zim64;
   assign zr2    = 32'(p_rr >>> FRAC);
   assign zi2    = 32'(p_ii >>> FRAC);
   assign zri    = 32'(p_ri >>> FRAC);
   assign mag    = 34'(zr2) + 34'(zi2);
   assign escape = (mag > ESC_LIM);
   assign at_cap = (n == MAX_N);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = ITER;
         ITER:    if (escape || at_cap) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         z_re        <= '0;
         z_im        <= '0;
         cr          <= '0;
         ci          <= '0;
         n           <= '0;
         out_x       <= '0;
         out_y       <= '0;
         out_iter    <= '0;
         out_escaped <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cr    <= c_re;
                  ci    <= c_im;
                  out_x <= in_x;
                  out_y <= in_y;
                  z_re  <= '0;
                  z_im  <= '0;
                  n     <= '0;
               end
            end
            ITER: begin
               // On escape z is frozen; the result registers carry the count.
               if (escape) begin
                  out_iter    <= n;
                  out_escaped <= 1'b1;
               end else if (at_cap) begin
                  out_iter    <= MAX_N;
                  out_escaped <= 1'b0;
               end else begin
                  z_re <= zr2 - zi2 + cr;
                  z_im <= zri + zri + ci;
                  n    <= n + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MANDEL_ITER_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         perf_cycles <= '0;
      else if (state == ITER && perf_cycles != 32'hFFFF_FFFF)
         perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed bench for mandelbrot_iterator: hand-computed escape counts, latency, stall, reset abort.
module tb_mandelbrot_iterator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] c_re;
   logic [31:0] c_im;
   logic [9:0]  in_x;
   logic [8:0]  in_y;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_iter;
   logic        out_escaped;
   logic [9:0]  out_x;
   logic [8:0]  out_y;
`ifdef MANDEL_ITER_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   int total = 0;
   int fails = 0;

   mandelbrot_iterator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .c_re        (c_re),
      .c_im        (c_im),
      .in_x        (in_x),
      .in_y        (in_y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_iter    (out_iter),
      .out_escaped (out_escaped),
      .out_x       (out_x),
      .out_y       (out_y)
`ifdef MANDEL_ITER_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller is idle, 1 time unit after an edge. Accepts one point, measures edges to out_valid, drains it.
   task automatic run_point(input string tag, input logic [31:0] cre, input logic [31:0] cim,
                            input logic [9:0] x, input logic [8:0] y,
                            input int exp_iter, input logic exp_esc);
      int lat;
      in_valid = 1'b1;
      c_re = cre;
      c_im = cim;
      in_x = x;
      in_y = y;
      @(posedge clk); #1;
      in_valid = 1'b0;
      c_re = 32'hDEAD_BEEF;
      c_im = 32'h1234_5678;
      lat = 0;
      while (!out_valid && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_iter + 1));
      chk({tag, "_iter"},    64'(out_iter), 64'(exp_iter));
      chk({tag, "_escaped"}, 64'(out_escaped), 64'(exp_esc));
      chk({tag, "_x"},       64'(out_x), 64'(x));
      chk({tag, "_y"},       64'(out_y), 64'(y));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
      chk({tag, "_valid_after"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      c_re      = '0;
      c_im      = '0;
      in_x      = '0;
      in_y      = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",    64'(in_ready), 64'd1);
      chk("rst_out_valid",   64'(out_valid), 64'd0);
      chk("rst_out_iter",    64'(out_iter), 64'd0);
      chk("rst_out_escaped", 64'(out_escaped), 64'd0);
      chk("rst_out_x",       64'(out_x), 64'd0);
      chk("rst_out_y",       64'(out_y), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_valid", 64'(in_ready), 64'd1);

      // (2,0): z=2, |z|^2=4 not >4, z=6 escapes at n=2.
      run_point("c2_0", 32'h0002_0000, 32'h0000_0000, 10'd1, 9'd2, 2, 1'b1);
      // (-2,0): z settles at 2, |z|^2 exactly 4 forever, never escapes.
      run_point("cm2_0", 32'hFFFE_0000, 32'h0000_0000, 10'd3, 9'd4, 255, 1'b0);
      run_point("c0_0", 32'h0000_0000, 32'h0000_0000, 10'd0, 9'd0, 255, 1'b0);
      // (1,1): |z1|^2=2 does not escape, z2=(1,3) escapes at n=2.
      run_point("c1_1", 32'h0001_0000, 32'h0001_0000, 10'd639, 9'd479, 2, 1'b1);
      // (0.5,0): 0.5, 0.75, 1.0625, 1.6289, 3.1533 escapes at n=5.
      run_point("c05_0", 32'h0000_8000, 32'h0000_0000, 10'd100, 9'd200, 5, 1'b1);
      // (0,2): z1=(0,2) |z|^2=4, z2=(-4,2) escapes at n=2.
      run_point("c0_2", 32'h0000_0000, 32'h0002_0000, 10'd512, 9'd256, 2, 1'b1);
      // (-1,0): period-2 cycle 0,-1, never escapes.
      run_point("cm1_0", 32'hFFFF_0000, 32'h0000_0000, 10'd7, 9'd9, 255, 1'b0);

      // Stall in DONE while offering new points.
      in_valid = 1'b1;
      c_re = 32'h0002_0000;
      c_im = 32'h0;
      in_x = 10'd5;
      in_y = 9'd7;
      @(posedge clk); #1;
      c_re = 32'h0;
      in_x = 10'd900;
      in_y = 9'd300;
      repeat (3) @(posedge clk);
      #1;
      chk("stall_reach_done", 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_in_ready",  64'(in_ready), 64'd0);
         chk("stall_out_iter",  64'(out_iter), 64'd2);
         chk("stall_escaped",   64'(out_escaped), 64'd1);
         chk("stall_out_x",     64'(out_x), 64'd5);
         chk("stall_out_y",     64'(out_y), 64'd7);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("stall_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk("stall_nothing_taken", 64'(in_ready), 64'd1);
      chk("stall_no_valid",      64'(out_valid), 64'd0);

      // Reset aborts a point mid-iteration.
      in_valid = 1'b1;
      c_re = 32'h0;
      c_im = 32'h0;
      in_x = 10'd11;
      in_y = 9'd13;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_busy", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_in_ready",  64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_out_x",     64'(out_x), 64'd0);
      run_point("post_abort", 32'h0002_0000, 32'h0000_0000, 10'd21, 9'd22, 2, 1'b1);
`ifdef MANDEL_ITER_PERF_CNT_EN
      chk("perf_cycles", 64'(perf_cycles), 64'd3);
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
